atm_counter_arbiter: RTL and testbench

- Shares one 64-bit atomic counter (32-bit read bus) between NUM_REQ requesters.
- Sequences each 64-bit read as an uninterruptible low-beat/high-beat pair on the counter bus.
- Returns the assembled 64-bit value to the winning requester.
- Sits between the atm_counter read port and the requester blocks; it does not drive the counter's trig_i increment input.

---
 rtl/atm_counter_pkg.sv | 36 +++
 rtl/atm_counter_arbiter_rr_arbiter.sv | 21 ++
 rtl/atm_counter_arbiter.sv | 106 ++++++++++
 tb/tb_atm_counter_arbiter.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/atm_counter_pkg.sv
// rtl/atm_counter_pkg.sv - shared types, widths and round-robin helper for the counter arbiter
package atm_counter_pkg;

  localparam int CTR_BUS_W = 32;
  localparam int CTR_W     = 64;
  localparam int IDX_W     = 3;

  typedef enum logic [1:0] {
    IDLE,
    LO_REQ,
    HI_REQ,
    RESP
  } arb_state_e;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } rr_pick_t;

  // First set bit at or above ptr, wrapping at n-1 back to 0.
  function automatic rr_pick_t rr_pick(input logic [7:0] req, input logic [IDX_W-1:0] ptr,
                                       input int n);
    rr_pick_t r;
    int       j;
    r = '0;
    for (int k = 0; k < 8; k++) begin
      j = (int'(ptr) + k) % n;
      if (k < n && !r.found && req[j]) begin
        r.found = 1'b1;
        r.idx   = IDX_W'(j);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/atm_counter_arbiter_rr_arbiter.sv
// rtl/atm_counter_arbiter_rr_arbiter.sv - combinational round-robin pick from request vector and pointer
module rr_arbiter
  import atm_counter_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   idx,
  output logic               found
);

  rr_pick_t pick;

  always_comb begin
    pick  = rr_pick(8'(req), ptr, NUM_REQ);
    idx   = pick.idx;
    found = pick.found;
  end

endmodule

// File: rtl/atm_counter_arbiter.sv
// rtl/atm_counter_arbiter.sv - shares a 64-bit counter read port as atomic lo/hi beat pairs
module atm_counter_arbiter
  import atm_counter_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   rd_req_i,
  output logic [NUM_REQ-1:0]   rsp_valid_o,
  output logic [CTR_W-1:0]     rsp_data_o,
  output logic                 rsp_err_o,
  output logic                 busy_o,
  output logic                 ctr_req_o,
  output logic                 ctr_atomic_o,
  input  logic                 ctr_ack_i,
  input  logic [CTR_BUS_W-1:0] ctr_count_i
);

  localparam int TMO_W = $clog2(ACK_TIMEOUT);

  arb_state_e           state;
  arb_state_e           state_nxt;
  logic [IDX_W-1:0]     rr_ptr;
  logic [IDX_W-1:0]     gnt_idx;
  logic [IDX_W-1:0]     pick_idx;
  logic                 pick_found;
  logic [CTR_BUS_W-1:0] lo;
  logic [CTR_BUS_W-1:0] hi;
  logic [TMO_W-1:0]     tcnt;
  logic                 err;
  logic                 expired;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req   (rd_req_i),
    .ptr   (rr_ptr),
    .idx   (pick_idx),
    .found (pick_found)
  );

  assign expired = (tcnt == TMO_W'(ACK_TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      rr_ptr  <= '0;
      gnt_idx <= '0;
      lo      <= '0;
      hi      <= '0;
      tcnt    <= '0;
      err     <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          tcnt <= '0;
          err  <= 1'b0;
          if (pick_found) gnt_idx <= pick_idx;
        end
        LO_REQ, HI_REQ: begin
          // An ack landing in the expiry cycle is a normal ack.
          if (ctr_ack_i) begin
            tcnt <= '0;
            if (state == LO_REQ) lo <= ctr_count_i;
            else                 hi <= ctr_count_i;
          end else if (expired) begin
            tcnt <= '0;
            err  <= 1'b1;
          end else begin
            tcnt <= tcnt + TMO_W'(1);
          end
        end
        RESP: rr_ptr <= (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_found) state_nxt = LO_REQ;
      LO_REQ:  if (ctr_ack_i) state_nxt = HI_REQ;
               else if (expired) state_nxt = RESP;
      HI_REQ:  if (ctr_ack_i || expired) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ctr_req_o    = (state == LO_REQ) || (state == HI_REQ);
    ctr_atomic_o = (state == LO_REQ);
    busy_o       = (state != IDLE);
    rsp_valid_o  = '0;
    rsp_err_o    = 1'b0;
    rsp_data_o   = '0;
    if (state == RESP) begin
      rsp_valid_o = NUM_REQ'(1) << gnt_idx;
      rsp_err_o   = err;
      if (!err) rsp_data_o = {hi, lo};
    end
  end

endmodule

// File: tb/tb_atm_counter_arbiter.sv
// tb/tb_atm_counter_arbiter.sv - directed-vector bench for atm_counter_arbiter
module tb_atm_counter_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  rd_req_i;
  logic [3:0]  rsp_valid_o;
  logic [63:0] rsp_data_o;
  logic        rsp_err_o;
  logic        busy_o;
  logic        ctr_req_o;
  logic        ctr_atomic_o;
  logic        ctr_ack_i;
  logic [31:0] ctr_count_i;

  int n_vec = 0;
  int n_err = 0;

  // Counter model controls, written only by the stimulus thread.
  logic [63:0] load_val = '0;
  bit          load_tog = 0;
  bit          inc_en = 0;
  bit          hi_mute = 0;
  int          ack_delay = 0;

  // Counter model state, written only by the model process.
  logic [63:0] cnt = '0;
  logic [31:0] snap = '0;
  bit          load_seen = 0;
  int          wait_cnt = 0;

  atm_counter_arbiter #(.NUM_REQ(4), .ACK_TIMEOUT(15)) dut (
    .clk          (clk),
    .rst          (rst),
    .rd_req_i     (rd_req_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_data_o   (rsp_data_o),
    .rsp_err_o    (rsp_err_o),
    .busy_o       (busy_o),
    .ctr_req_o    (ctr_req_o),
    .ctr_atomic_o (ctr_atomic_o),
    .ctr_ack_i    (ctr_ack_i),
    .ctr_count_i  (ctr_count_i)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // Low beat returns the low word and snapshots the high word; high beat returns the snapshot.
  always @(posedge clk) begin
    #1;
    if (load_tog != load_seen) begin
      load_seen = load_tog;
      cnt = load_val;
    end
    ctr_ack_i   = 1'b0;
    ctr_count_i = '0;
    if (ctr_req_o && !(hi_mute && !ctr_atomic_o)) begin
      if (wait_cnt >= ack_delay) begin
        ctr_ack_i = 1'b1;
        if (ctr_atomic_o) begin
          ctr_count_i = cnt[31:0];
          snap = cnt[63:32];
        end else begin
          ctr_count_i = snap;
        end
        wait_cnt = 0;
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
    if (inc_en) cnt = cnt + 64'd1;
  end

  task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic load_ctr(input logic [63:0] v);
    load_val = v;
    load_tog = ~load_tog;
  endtask

  task automatic wait_rsp(output logic [3:0] v, output int cyc);
    v = '0;
    cyc = 0;
    while (cyc < 24) begin
      @(negedge clk);
      cyc++;
      if (rsp_valid_o != 0) begin
        v = rsp_valid_o;
        break;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [3:0] v;
  int         cyc;

  initial begin
    rst = 1; rd_req_i = '0; ctr_ack_i = 0; ctr_count_i = '0;
    repeat (2) @(negedge clk);
    check_vec("rst_valid", 64'(rsp_valid_o), 64'h0);
    check_vec("rst_busy", 64'(busy_o), 64'h0);
    check_vec("rst_ctr_req", 64'(ctr_req_o), 64'h0);
    check_vec("rst_atomic", 64'(ctr_atomic_o), 64'h0);
    check_vec("rst_data", rsp_data_o, 64'h0);
    check_vec("rst_err", 64'(rsp_err_o), 64'h0);
    rst = 0;

    // Single read, immediate ack: response in the 4th cycle counting the request cycle.
    @(negedge clk);
    load_ctr(64'h0000_0001_FFFF_FFFF);
    rd_req_i = 4'b0001;
    @(negedge clk);
    check_vec("single_lo_atomic", 64'(ctr_atomic_o), 64'h1);
    check_vec("single_lo_req", 64'(ctr_req_o), 64'h1);
    @(negedge clk);
    check_vec("single_hi_atomic", 64'(ctr_atomic_o), 64'h0);
    check_vec("single_hi_novalid", 64'(rsp_valid_o), 64'h0);
    @(negedge clk);
    check_vec("single_valid", 64'(rsp_valid_o), 64'h1);
    check_vec("single_data", rsp_data_o, 64'h0000_0001_FFFF_FFFF);
    check_vec("single_err", 64'(rsp_err_o), 64'h0);
    rd_req_i = '0;
    @(negedge clk);
    check_vec("single_idle", 64'(busy_o), 64'h0);

    // Round-robin with all four held; pointer sits at 1 after the single read.
    load_ctr(64'hDEAD_BEEF_0123_4567);
    rd_req_i = 4'b1111;
    for (int i = 0; i < 16; i++) begin
      wait_rsp(v, cyc);
      check_vec($sformatf("rr_grant%0d", i), 64'(v), 64'(4'b0001 << ((i + 1) % 4)));
      check_vec($sformatf("rr_gap%0d", i), 64'(cyc), (i == 0) ? 64'd3 : 64'd4);
      check_vec($sformatf("rr_data%0d", i), rsp_data_o, 64'hDEAD_BEEF_0123_4567);
    end
    rd_req_i = '0;
    @(negedge clk);

    // Counter ticking across the low-word wrap; requester 2 arrives mid-pair, requester 1 withdraws.
    inc_en = 1;
    load_ctr(64'h0000_0000_FFFF_FFFF);
    rd_req_i = 4'b0010;
    @(negedge clk);
    rd_req_i = 4'b0100;
    @(negedge clk);
    check_vec("wrap_midpair_busy", 64'(busy_o), 64'h1);
    @(negedge clk);
    check_vec("wrap_valid", 64'(rsp_valid_o), 64'b0010);
    check_vec("wrap_data", rsp_data_o, 64'h0000_0000_FFFF_FFFF);
    wait_rsp(v, cyc);
    check_vec("wrap_second_valid", 64'(v), 64'b0100);
    check_vec("wrap_second_gap", 64'(cyc), 64'd4);
    check_vec("wrap_second_data", rsp_data_o, 64'h0000_0001_0000_0003);
    rd_req_i = '0;
    inc_en = 0;
    @(negedge clk);

    // Slow ack on the third cycle of each beat: response in the 8th cycle.
    ack_delay = 2;
    load_ctr(64'h0000_00AB_0000_00CD);
    rd_req_i = 4'b1000;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      check_vec($sformatf("slow_req_held%0d", k), 64'(ctr_req_o), 64'h1);
      check_vec($sformatf("slow_atomic%0d", k), 64'(ctr_atomic_o), (k <= 3) ? 64'h1 : 64'h0);
    end
    @(negedge clk);
    check_vec("slow_valid", 64'(rsp_valid_o), 64'b1000);
    check_vec("slow_data", rsp_data_o, 64'h0000_00AB_0000_00CD);
    rd_req_i = '0;
    ack_delay = 0;
    @(negedge clk);

    // High beat never acked: error response 15 cycles after HI_REQ is entered.
    hi_mute = 1;
    rd_req_i = 4'b0001;
    cyc = 0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (rsp_valid_o != 0) cyc++;
    end
    check_vec("tmo_early_valid", 64'(cyc), 64'd0);
    check_vec("tmo_waiting_busy", 64'(busy_o), 64'h1);
    @(negedge clk);
    check_vec("tmo_valid", 64'(rsp_valid_o), 64'b0001);
    check_vec("tmo_err", 64'(rsp_err_o), 64'h1);
    check_vec("tmo_data", rsp_data_o, 64'h0);
    rd_req_i = '0;
    hi_mute = 0;
    @(negedge clk);
    check_vec("tmo_idle", 64'(busy_o), 64'h0);
    load_ctr(64'h5555_AAAA_1234_0000);
    rd_req_i = 4'b0010;
    repeat (3) @(negedge clk);
    check_vec("tmo_next_valid", 64'(rsp_valid_o), 64'b0010);
    check_vec("tmo_next_err", 64'(rsp_err_o), 64'h0);
    check_vec("tmo_next_data", rsp_data_o, 64'h5555_AAAA_1234_0000);
    rd_req_i = '0;
    @(negedge clk);

    // Reset during HI_REQ; pointer is 2 beforehand, so a post-reset 0110 shows whether it cleared.
    hi_mute = 1;
    rd_req_i = 4'b0100;
    repeat (2) @(negedge clk);
    check_vec("rstmid_in_hi", 64'({busy_o, ctr_atomic_o}), 64'b10);
    #2;
    rst = 1;
    #1;
    check_vec("rstmid_busy", 64'(busy_o), 64'h0);
    check_vec("rstmid_ctr_req", 64'(ctr_req_o), 64'h0);
    check_vec("rstmid_valid", 64'(rsp_valid_o), 64'h0);
    rd_req_i = '0;
    cyc = 0;
    repeat (3) begin
      @(negedge clk);
      if (rsp_valid_o != 0 || busy_o) cyc++;
    end
    check_vec("rstmid_quiet", 64'(cyc), 64'd0);
    rst = 0;
    hi_mute = 0;
    load_ctr(64'h0000_0002_0000_0003);
    rd_req_i = 4'b0110;
    repeat (3) @(negedge clk);
    check_vec("rstmid_grant1", 64'(rsp_valid_o), 64'b0010);
    check_vec("rstmid_data", rsp_data_o, 64'h0000_0002_0000_0003);
    rd_req_i = '0;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
